// File: rtl/coproc_pkg.sv
// Shared types and answer-word bit offsets for the GCD/LCM coprocessor.
package coproc_pkg;

    typedef enum logic {
        MODE_GCD = 1'b0,
        MODE_LCM = 1'b1
    } cop_mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GCD  = 3'd1,
        S_DIV  = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } cop_state_e;

    function automatic int unsigned ans_done_bit(input int unsigned width);
        return width;
    endfunction

    function automatic int unsigned ans_err_bit(input int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned ans_ovf_bit(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unit: restoring divide (op=0, quo = x/y) or shift-add multiply (op=1, prod = x*y).
// Both use one 2*WIDTH accumulator and take WIDTH cycles after go; ready is high when idle.
module seq_muldiv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 op,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 ready,
    output logic [WIDTH-1:0]     quo,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic               running_q;
    logic               op_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   y_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     sum;

    // Divide: acc = {remainder, dividend/quotient}. Multiply: acc = {partial, multiplier}.
    always_comb begin
        trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff  = trial - {1'b0, y_q};
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, y_q} : '0);
        if (op_q) begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end else if (trial >= {1'b0, y_q}) begin
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running_q <= 1'b0;
            op_q      <= 1'b0;
            cnt_q     <= '0;
            y_q       <= '0;
            acc_q     <= '0;
        end else if (go) begin
            running_q <= 1'b1;
            op_q      <= op;
            cnt_q     <= '0;
            y_q       <= y;
            acc_q     <= {{WIDTH{1'b0}}, x};
        end else if (running_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                running_q <= 1'b0;
            end
        end
    end

    assign ready = ~running_q;
    assign quo   = acc_q[WIDTH-1:0];
    assign prod  = acc_q;

endmodule

// File: rtl/gcd_lcm_coproc.sv
// Multi-cycle GCD/LCM coprocessor with packed answer word for memory-mapped readback.
// LCM datapath is present only when GCD_LCM_LCM_EN is defined; otherwise mode=1 reports err.
module gcd_lcm_coproc
    import coproc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             err,
    output logic [31:0]      ans_word
);

    localparam int unsigned DONE_BIT = ans_done_bit(WIDTH);
    localparam int unsigned ERR_BIT  = ans_err_bit(WIDTH);
    localparam int unsigned OVF_BIT  = ans_ovf_bit(WIDTH);

    cop_state_e       state_q, state_d;
    cop_mode_e        mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d, err_q, err_d;
    logic             gcd_hit;
    logic [WIDTH-1:0] g;

`ifdef GCD_LCM_LCM_EN
    logic [WIDTH-1:0]   orig_a_q, orig_b_q;
    logic               md_go, md_op, md_ready;
    logic [WIDTH-1:0]   md_x, md_y, md_quo;
    logic [2*WIDTH-1:0] md_prod;

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .go    (md_go),
        .op    (md_op),
        .x     (md_x),
        .y     (md_y),
        .ready (md_ready),
        .quo   (md_quo),
        .prod  (md_prod)
    );
`endif

    // Zero operands only exist on the first GCD cycle; unequal nonzero steps never reach 0.
    always_comb begin
        gcd_hit = 1'b1;
        g       = a_q;
        if (a_q == '0) begin
            g = b_q;
        end else if (b_q == '0 || a_q == b_q) begin
            g = a_q;
        end else begin
            gcd_hit = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
`ifdef GCD_LCM_LCM_EN
        md_go = 1'b0;
        md_op = 1'b0;
        md_x  = '0;
        md_y  = '0;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_GCD;
                    mode_d   = cop_mode_e'(mode);
                    a_d      = op_a;
                    b_d      = op_b;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            S_GCD: begin
                if (!gcd_hit) begin
                    if (a_q > b_q) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                end
`ifdef GCD_LCM_LCM_EN
                if (gcd_hit && mode_q == MODE_LCM) begin
                    if (a_q == '0 || b_q == '0) begin
                        state_d  = S_DONE;
                        result_d = '0;
                    end else begin
                        state_d = S_DIV;
                        md_go   = 1'b1;
                        md_x    = orig_a_q;
                        md_y    = g;
                    end
                end else if (gcd_hit) begin
                    state_d  = S_DONE;
                    result_d = g;
                end
`else
                if (mode_q == MODE_LCM) begin
                    state_d  = S_DONE;
                    err_d    = 1'b1;
                    result_d = '0;
                end else if (gcd_hit) begin
                    state_d  = S_DONE;
                    result_d = g;
                end
`endif
            end
`ifdef GCD_LCM_LCM_EN
            S_DIV: begin
                if (md_ready) begin
                    state_d = S_MUL;
                    md_go   = 1'b1;
                    md_op   = 1'b1;
                    md_x    = md_quo;
                    md_y    = orig_b_q;
                end
            end
            S_MUL: begin
                if (md_ready) begin
                    state_d  = S_DONE;
                    result_d = md_prod[WIDTH-1:0];
                    ovf_d    = |md_prod[2*WIDTH-1:WIDTH];
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE_GCD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

`ifdef GCD_LCM_LCM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            orig_a_q <= '0;
            orig_b_q <= '0;
        end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            orig_a_q <= op_a;
            orig_b_q <= op_b;
        end
    end
`endif

    assign busy   = (state_q == S_GCD) || (state_q == S_DIV) || (state_q == S_MUL);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;
    assign err    = err_q;

    always_comb begin
        ans_word              = '0;
        ans_word[WIDTH-1:0]   = result_q;
        ans_word[DONE_BIT]    = done;
        ans_word[ERR_BIT]     = err_q;
        ans_word[OVF_BIT]     = ovf_q;
    end

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Directed bench for gcd_lcm_coproc (WIDTH=8); LCM vectors run only when GCD_LCM_LCM_EN is defined.
module tb_gcd_lcm_coproc;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         mode;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;
    logic         err;
    logic [31:0]  ans_word;

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    gcd_lcm_coproc #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .err      (err),
        .ans_word (ans_word)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns on the first negedge after the accepting posedge.
    task automatic start_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges seen busy before done; flags gaps and an expired bound.
    task automatic wait_done(input string tag, input int limit, output int cycles);
        int gaps;
        gaps   = 0;
        cycles = 0;
        while (!done && cycles < limit) begin
            if (!busy) gaps++;
            cycles++;
            @(negedge clk);
        end
        check({tag, "_busy_gap"}, gaps, 0);
        check({tag, "_done"}, {31'b0, done}, 1);
        check({tag, "_busy_clr"}, {31'b0, busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_result", {24'b0, result}, 0);
        check("rst_flags", {30'b0, ovf, err}, 0);
        check("rst_ans", ans_word, 0);
        reset = 1'b1;
        @(negedge clk);

        // GCD 48,18 with an ignored second start (9,3) one cycle in
        start_op(1'b0, 8'd48, 8'd18);
        check("acc_busy", {31'b0, busy}, 1);
        check("acc_done", {31'b0, done}, 0);
        start = 1'b1;
        op_a  = 8'd9;
        op_b  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("g48_18", 300, cyc);
        check("g48_18_cycles", cyc, 4);
        check("g48_18_result", {24'b0, result}, 6);
        check("g48_18_flags", {30'b0, ovf, err}, 0);
        check("g48_18_ans", ans_word, 32'h106);
        repeat (3) @(negedge clk);
        check("sticky_done", {31'b0, done}, 1);
        check("sticky_result", {24'b0, result}, 6);

        // Restart after done
        start_op(1'b0, 8'd9, 8'd3);
        wait_done("g9_3", 300, cyc);
        check("g9_3_cycles", cyc, 3);
        check("g9_3_result", {24'b0, result}, 3);

        // Zero operands resolve in the first GCD cycle
        start_op(1'b0, 8'd0, 8'd7);
        wait_done("g0_7", 300, cyc);
        check("g0_7_cycles", cyc, 1);
        check("g0_7_result", {24'b0, result}, 7);
        start_op(1'b0, 8'd0, 8'd0);
        wait_done("g0_0", 300, cyc);
        check("g0_0_cycles", cyc, 1);
        check("g0_0_result", {24'b0, result}, 0);
        start_op(1'b0, 8'd7, 8'd0);
        wait_done("g7_0", 300, cyc);
        check("g7_0_result", {24'b0, result}, 7);

        // Start coincident with the DONE transition is ignored
        start_op(1'b0, 8'd9, 8'd3);
        repeat (2) @(negedge clk);
        start = 1'b1;
        op_a  = 8'd5;
        op_b  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        check("race_done", {31'b0, done}, 1);
        check("race_result", {24'b0, result}, 3);
        @(negedge clk);
        check("race_busy", {31'b0, busy}, 0);
        check("race_still_done", {31'b0, done}, 1);

`ifdef GCD_LCM_LCM_EN
        start_op(1'b1, 8'd4, 8'd6);
        wait_done("l4_6", 300, cyc);
        check("l4_6_result", {24'b0, result}, 12);
        check("l4_6_ovf", {31'b0, ovf}, 0);
        start_op(1'b1, 8'd255, 8'd254);
        wait_done("l255_254", 1000, cyc);
        check("l255_254_result", {24'b0, result}, 2);
        check("l255_254_ovf", {31'b0, ovf}, 1);
        check("l255_254_ans", ans_word, 32'h502);
        start_op(1'b1, 8'd0, 8'd7);
        wait_done("l0_7", 300, cyc);
        check("l0_7_cycles", cyc, 1);
        check("l0_7_result", {24'b0, result}, 0);
        // Reset dropped mid-LCM
        start_op(1'b1, 8'd12, 8'd18);
        repeat (6) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("lrst_outputs", {busy, done, ovf, err, result}, 0);
        check("lrst_ans", ans_word, 0);
        @(negedge clk);
        reset = 1'b1;
        start_op(1'b1, 8'd12, 8'd18);
        wait_done("l12_18", 300, cyc);
        check("l12_18_result", {24'b0, result}, 36);
`else
        start_op(1'b1, 8'd5, 8'd3);
        wait_done("nolcm", 300, cyc);
        check("nolcm_cycles", cyc, 1);
        check("nolcm_err", {31'b0, err}, 1);
        check("nolcm_result", {24'b0, result}, 0);
        check("nolcm_ovf", {31'b0, ovf}, 0);
        check("nolcm_ans", ans_word, 32'h300);
`endif

        // Accept clears err; reset mid-GCD aborts on the same edge
        start_op(1'b0, 8'd200, 8'd1);
        check("acc_err_clr", {31'b0, err}, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("grst_outputs", {busy, done, ovf, err, result}, 0);
        check("grst_ans", ans_word, 0);
        @(negedge clk);
        reset = 1'b1;
        start_op(1'b0, 8'd12, 8'd8);
        wait_done("g12_8", 300, cyc);
        check("g12_8_cycles", cyc, 3);
        check("g12_8_result", {24'b0, result}, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
